// File: rtl/dmem_responder_if.sv
// Request/response bundle between the core-side load/store wrapper and dmem_responder.
interface dmem_responder_if;
    logic        mem_en;
    logic        Load;
    logic [31:0] addr;
    logic [3:0]  masking;
    logic [31:0] data_i;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output mem_en, Load, addr, masking, data_i,
        input  req_ready, rsp_valid, rdata, err
    );

    modport slave (
        input  mem_en, Load, addr, masking, data_i,
        output req_ready, rsp_valid, rdata, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-port data memory responder with byte-lane writes and range checking.
// Define DMEM_WAIT_EN to insert WAIT_CYCLES of extra access latency.
//
// state | meaning
// IDLE  | ready to accept a request
// WAIT  | request captured, counting down extra latency (DMEM_WAIT_EN only)
// RESP  | access done this edge; rsp_valid high for one cycle
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_next;

    logic [31:0] mem [0:(1 << ADDR_W) - 1];
    logic [31:0] rdata_q;
    logic        err_q;

    logic              accept;
    logic              access;
    logic              op_load;
    logic [31:0]       op_addr;
    logic [3:0]        op_mask;
    logic [31:0]       op_data;
    logic [ADDR_W-1:0] idx;
    logic              oor;
    logic              unused_addr_lsb;

    assign accept = (state == IDLE) && bus.mem_en && !rst;

`ifdef DMEM_WAIT_EN
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;
    logic             cap_load;
    logic [31:0]      cap_addr;
    logic [3:0]       cap_mask;
    logic [31:0]      cap_data;

    // Down-counter: loaded on accept, WAIT exits at terminal count zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_W'(WAIT_CYCLES - 1);
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_load <= bus.Load;
            cap_addr <= bus.addr;
            cap_mask <= bus.masking;
            cap_data <= bus.data_i;
        end
    end

    // With WAIT_CYCLES=0 the access happens on the accept edge from live inputs.
    assign op_load = (state == IDLE) ? bus.Load    : cap_load;
    assign op_addr = (state == IDLE) ? bus.addr    : cap_addr;
    assign op_mask = (state == IDLE) ? bus.masking : cap_mask;
    assign op_data = (state == IDLE) ? bus.data_i  : cap_data;
`else
    localparam int unused_wait_cycles = WAIT_CYCLES;

    assign op_load = bus.Load;
    assign op_addr = bus.addr;
    assign op_mask = bus.masking;
    assign op_data = bus.data_i;
`endif

    assign idx             = op_addr[ADDR_W+1:2];
    assign oor             = (op_addr >> (ADDR_W + 2)) != 32'd0;
    assign unused_addr_lsb = ^op_addr[1:0];

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef DMEM_WAIT_EN
                    state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
`else
                    state_next = RESP;
`endif
                end
            end
`ifdef DMEM_WAIT_EN
            WAIT:    if (cnt == '0) state_next = RESP;
`endif
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The access is performed on the edge that enters RESP; reset cancels it.
    assign access = !rst && (state_next == RESP);

    always_ff @(posedge clk) begin
        if (access && !op_load && !oor) begin
            for (int i = 0; i < 4; i++) begin
                if (op_mask[i]) mem[idx][8*i +: 8] <= op_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (access) begin
                err_q   <= oor;
                rdata_q <= (op_load && !oor) ? mem[idx] : 32'd0;
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder; expected responses are queued at each accept.
module tb_dmem_responder;
    localparam int ADDR_W = 8;
    localparam int W      = 2;
`ifdef DMEM_WAIT_EN
    localparam int LAT = 1 + W;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    dmem_responder_if bus ();

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          rsp_cnt = 0;
    exp_t        sb[$];
    logic [31:0] model [0:(1 << ADDR_W) - 1];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.rsp_valid) begin
            rsp_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rdata", bus.rdata, e.rdata);
                chk("err", {31'd0, bus.err}, {31'd0, e.err});
                chk("latency", cyc, e.due);
            end
        end
    end

    // Expected response plus model update, evaluated right after the accepting edge.
    task automatic push_exp(input logic ld, input logic [31:0] a, input logic [3:0] m,
                            input logic [31:0] d);
        exp_t        e;
        logic        o;
        logic [7:0]  ix;
        o  = (a >> (ADDR_W + 2)) != 32'd0;
        ix = a[ADDR_W+1:2];
        e.err   = o;
        e.rdata = (ld && !o) ? model[ix] : 32'd0;
        e.due   = cyc + LAT - 1;
        sb.push_back(e);
        if (!ld && !o) begin
            for (int i = 0; i < 4; i++) if (m[i]) model[ix][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    task automatic issue(input logic ld, input logic [31:0] a, input logic [3:0] m,
                         input logic [31:0] d, input bit expect_rsp);
        int n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
        bus.mem_en = 1'b1; bus.Load = ld; bus.addr = a; bus.masking = m; bus.data_i = d;
        @(posedge clk);
        #1;
        if (expect_rsp) push_exp(ld, a, m, d);
        bus.mem_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int rsp0;
        logic rdy;

        bus.mem_en = 1'b0; bus.Load = 1'b0; bus.addr = '0; bus.masking = '0; bus.data_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);

        // Full write then read back, plus lane-merge and zero-mask writes.
        issue(1'b0, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1);
        issue(1'b1, 32'h10, 4'h0, 32'h0, 1'b1);
        issue(1'b0, 32'h20, 4'hF, 32'h11223344, 1'b1);
        issue(1'b0, 32'h20, 4'b0010, 32'h0000AA00, 1'b1);
        issue(1'b1, 32'h20, 4'hF, 32'h0, 1'b1);
        issue(1'b0, 32'h10, 4'b0000, 32'h12345678, 1'b1);
        issue(1'b1, 32'h13, 4'h0, 32'h0, 1'b1);
        drain();
        chk("merge_0x20", model[8], 32'h1122AA44);
        repeat (3) @(negedge clk);
        chk("rdata_hold", bus.rdata, 32'hDEADBEEF);

        // Out-of-range accesses must not alias onto word 0.
        issue(1'b0, 32'h0, 4'hF, 32'h0BADF00D, 1'b1);
        issue(1'b1, 32'h400, 4'h0, 32'h0, 1'b1);
        issue(1'b0, 32'h400, 4'hF, 32'hFFFFFFFF, 1'b1);
        issue(1'b1, 32'h0, 4'h0, 32'h0, 1'b1);
        issue(1'b1, 32'h8000_0010, 4'h0, 32'h0, 1'b1);
        drain();

        // mem_en held high for six cycles.
        rsp0 = rsp_cnt;
        acc  = 0;
        bus.mem_en = 1'b1; bus.Load = 1'b1; bus.addr = 32'h10; bus.masking = 4'h0;
        for (int i = 0; i < 6; i++) begin
            rdy = bus.req_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                push_exp(1'b1, 32'h10, 4'h0, 32'h0);
                acc++;
            end
        end
        bus.mem_en = 1'b0;
        @(negedge clk);
        drain();
        chk("burst_accepts", acc, (6 + LAT) / (LAT + 1));
        chk("burst_pulses", rsp_cnt - rsp0, (6 + LAT) / (LAT + 1));

        // Reset coincident with a request wins; memory survives reset.
        issue(1'b0, 32'h30, 4'hF, 32'h55667788, 1'b1);
        issue(1'b1, 32'h04, 4'h0, 32'h0, 1'b1);
        drain();
        rst = 1'b1;
        bus.mem_en = 1'b1; bus.Load = 1'b0; bus.addr = 32'h30; bus.masking = 4'hF;
        bus.data_i = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.mem_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_pri_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_pri_rdata", bus.rdata, 32'd0);
        issue(1'b1, 32'h30, 4'h0, 32'h0, 1'b1);
        drain();

`ifdef DMEM_WAIT_EN
        // Reset during WAIT drops the pending write and its response.
        issue(1'b0, 32'h30, 4'hF, 32'hCAFEF00D, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        repeat (5) @(negedge clk);
        issue(1'b1, 32'h30, 4'h0, 32'h0, 1'b1);
        drain();
`endif

        repeat (3) @(negedge clk);
        chk("final_ready", {31'd0, bus.req_ready}, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: ADDR_W, default 8, word-address width; memory holds 2^ADDR_W 32-bit words.
REQ-002 Parameter: WAIT_CYCLES, default 2, extra access latency in cycles; used only when DMEM_WAIT_EN is defined.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: mem_en  input  1  request strobe from the core-side load/store wrapper.
REQ-006 Port: Load  input  1  request type; 1 = read, 0 = write.
REQ-007 Port: addr  input  32  byte address; word index = addr[ADDR_W+1:2]; addr[1:0] ignored.
REQ-008 Port: masking  input  4  write byte enables; bit i selects byte lane i (bits 8i+7:8i).
REQ-009 Port: data_i  input  32  lane-aligned write data.
REQ-010 Port: req_ready  output  1  responder can accept a request this cycle.
REQ-011 Port: rsp_valid  output  1  one-cycle pulse; access complete; rdata/err valid.
REQ-012 Port: rdata  output  32  full read word, returned unaligned to the core-side wrapper's load input.
REQ-013 Port: err  output  1  qualified by rsp_valid; address out of range.

Function
REQ-014 States SHALL be IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 Request SHALL be accepted on a rising edge where mem_en=1 and req_ready=1; Load, addr, masking and data_i SHALL be captured at that edge.
REQ-016 mem_en while req_ready=0 SHALL be ignored, with no capture or queuing.
REQ-017 IDLE->RESP on accept (DMEM_WAIT_EN undefined, or WAIT_CYCLES=0); RESP->IDLE unconditionally after one cycle.
REQ-018 Latency from accepting edge to rsp_valid=1 SHALL be 1 cycle without waits; peak throughput SHALL be one request per 2 cycles.
REQ-019 Access SHALL execute on the edge entering RESP: the write updates enabled lanes only, and the read samples the word after that edge's write, if any.
REQ-020 Read: rdata SHALL be the full stored word regardless of masking; the write path SHALL leave rdata = 0.
REQ-021 Write with masking=4'b0000 SHALL modify nothing and still produce rsp_valid with err=0.
REQ-022 Out of range (any bit of addr[31:ADDR_W+2] set) SHALL suppress the write, force rdata=0 and set err=1 for the RESP cycle.
REQ-023 rdata and err SHALL hold their values until the next RESP; rsp_valid SHALL be high exactly one cycle per accepted request, with no backpressure.

Reset
REQ-024 rst=1 SHALL force state=IDLE and the following output values on the next edge: req_ready=1, rsp_valid=0, rdata=0, err=0.
REQ-025 Reset mid-access (WAIT or RESP) SHALL drop the pending request and produce no rsp_valid; a write not yet executed SHALL NOT occur.
REQ-026 Memory array contents SHALL NOT be cleared by rst.
REQ-027 rst SHALL take priority over a simultaneous mem_en.

Configuration
REQ-028 Macro DMEM_WAIT_EN defined: IDLE->WAIT on accept; WAIT SHALL count WAIT_CYCLES cycles, then go to RESP; latency = 1+WAIT_CYCLES.
REQ-029 Macro DMEM_WAIT_EN undefined: WAIT SHALL be unreachable and the counter SHALL be absent; behaviour as REQ-017/018.

Verification
REQ-030 Write addr=0x10, data_i=0xDEADBEEF, masking=4'hF, then read 0x10 -> rsp_valid 1 cycle after each accept, rdata=0xDEADBEEF, err=0.
REQ-031 Preload 0x11223344 at 0x20; write masking=4'b0010, data_i=0x0000AA00; read 0x20 -> rdata=0x1122AA44.
REQ-032 Read addr=0x400 (ADDR_W=8) -> rdata=0, err=1; a following write to 0x400 leaves word 0 unchanged.
REQ-033 mem_en held high for 6 cycles -> exactly 3 accepts and 3 rsp_valid pulses (no waits); 2 accepts (DMEM_WAIT_EN, WAIT_CYCLES=2, latency 3).
REQ-034 Write to 0x30 accepted, rst asserted the next cycle (DMEM_WAIT_EN, WAIT_CYCLES=2) -> no rsp_valid, read 0x30 returns the prior value, req_ready=1 after reset.
